// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: shared FSM state type and transmitter status levels
package uart_tx_feeder_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, SENDING} state_e;
  localparam logic ST_IDLE = 1'b1;
  localparam logic ST_BUSY = 1'b0;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: producer write port plus transmitter control/status bundle
interface uart_tx_feeder_if #(
  parameter int DEPTH = 16
) ();
  localparam int LW = $clog2(DEPTH) + 1;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [LW-1:0] level;
  logic [7:0]    tx_data;
  logic          tx_go;
  logic          tx_status;
  logic          overflow;
  logic          timeout;
  logic [15:0]   sent_count;
  modport master (
    output wr_en, wr_data, tx_status,
    input  full, level, tx_data, tx_go, overflow, timeout, sent_count
  );
  modport slave (
    input  wr_en, wr_data, tx_status,
    output full, level, tx_data, tx_go, overflow, timeout, sent_count
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: circular byte buffer with count; no fall-through
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_i,
  input  logic [7:0]             wdata_i,
  input  logic                   rd_i,
  output logic [7:0]             rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign push    = wr_i && !full_o;
  assign pop     = rd_i && !empty_o;
  assign rdata_o = mem_q[rp_q];
  assign count_o = cnt_q;
  always_comb begin
    wp_d  = push ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= wdata_i;
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers bytes and sequences them into a UART transmitter,
// gating it through rst_n and advancing on its synchronized status edges
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ARM_TIMEOUT = 4096
) (
  input logic            clk,
  input logic            rst,
  uart_tx_feeder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(ARM_TIMEOUT) + 1;
  logic [1:0]    sync_q;
  logic          st_q, st_s, fall, rise;
  logic          pop, empty;
  logic [7:0]    head;
  logic [CW-1:0] cnt;
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    data_q, data_d;
  logic          go_q, go_d, ovf_q, ovf_d, to_q, to_d;
  logic [15:0]   sent_q, sent_d;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr_i(bus.wr_en), .wdata_i(bus.wr_data), .rd_i(pop),
    .rdata_o(head), .count_o(cnt), .full_o(bus.full), .empty_o(empty)
  );

  // tx_status is launched from the divided-clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{ST_IDLE}};
      st_q   <= ST_IDLE;
    end else begin
      sync_q <= {sync_q[0], bus.tx_status};
      st_q   <= sync_q[1];
    end
  end
  assign st_s = sync_q[1];
  assign fall = (st_q == ST_IDLE) && (st_s == ST_BUSY);
  assign rise = (st_q == ST_BUSY) && (st_s == ST_IDLE);

  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = empty ? IDLE : ARMED;
      ARMED:   state_d = fall ? SENDING : (tmr_q == TW'(ARM_TIMEOUT - 1)) ? IDLE : ARMED;
      SENDING: state_d = !rise ? SENDING : empty ? IDLE : ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop    = !empty && ((state_q == IDLE) || (state_q == SENDING && rise));
    go_d   = state_d != IDLE;
    data_d = pop ? head : data_q;
    tmr_d  = (state_q == ARMED && state_d == ARMED) ? tmr_q + TW'(1) : '0;
    to_d   = to_q || (state_q == ARMED && state_d == IDLE);
    ovf_d  = ovf_q || (bus.wr_en && bus.full);
    sent_d = sent_q + 16'(state_q == SENDING && rise);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q  <= '0;
      data_q <= 8'h00;
      go_q   <= 1'b0;
      ovf_q  <= 1'b0;
      to_q   <= 1'b0;
      sent_q <= '0;
    end else begin
      tmr_q  <= tmr_d;
      data_q <= data_d;
      go_q   <= go_d;
      ovf_q  <= ovf_d;
      to_q   <= to_d;
      sent_q <= sent_d;
    end
  end

  assign bus.level      = cnt;
  assign bus.tx_data    = data_q;
  assign bus.tx_go      = go_q;
  assign bus.overflow   = ovf_q;
  assign bus.timeout    = to_q;
  assign bus.sent_count = sent_q;
endmodule
